// File: rtl/keypad_operand_entry.sv
// Registered keypad operand entry: decodes keycodes, assembles hex digits and emits operand/opcode pulses.
// Optional build macro KEYPAD_LEADZERO_SUPPRESS_EN: ignore a 0 digit typed while the entry is empty.
module keypad_operand_entry #(
   parameter int DIGITS = 4,
   parameter int CW     = $clog2(DIGITS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                newkey,
   input  logic [4:0]          keycode,
   output logic [4*DIGITS-1:0] entry,
   output logic [CW-1:0]       ndigits,
   output logic                full,
   output logic                emit_valid,
   output logic [4*DIGITS-1:0] emit_operand,
   output logic [1:0]          emit_opcode,
   output logic                emit_eq,
   output logic                overflow,
   output logic                clear
);

   localparam int W = 4 * DIGITS;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;

   localparam logic [4:0] K_ADD = 5'b01010;
   localparam logic [4:0] K_SUB = 5'b00011;
   localparam logic [4:0] K_MUL = 5'b00010;
   localparam logic [4:0] K_BS  = 5'b00001;
   localparam logic [4:0] K_CLR = 5'b01001;
   localparam logic [4:0] K_EQ  = 5'b00100;

   typedef enum logic [1:0] {EMPTY, ENTRY, FULL} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  entry_q, entry_d;
   logic [CW-1:0] n_q, n_d;
   logic [1:0]    op_q, op_d;
   logic [W-1:0]  emit_operand_q, emit_operand_d;
   logic [1:0]    emit_opcode_q, emit_opcode_d;
   logic          emit_valid_q, emit_valid_d;
   logic          emit_eq_q, emit_eq_d;
   logic          overflow_q, overflow_d;
   logic          clear_q, clear_d;
   logic          full_q, full_d;
   logic          lead_zero;

`ifdef KEYPAD_LEADZERO_SUPPRESS_EN
   assign lead_zero = (state_q == EMPTY) && (keycode[3:0] == 4'h0);
`else
   assign lead_zero = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= EMPTY;
         entry_q        <= '0;
         n_q            <= '0;
         op_q           <= OP_ADD;
         emit_operand_q <= '0;
         emit_opcode_q  <= OP_ADD;
         emit_valid_q   <= 1'b0;
         emit_eq_q      <= 1'b0;
         overflow_q     <= 1'b0;
         clear_q        <= 1'b0;
         full_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         entry_q        <= entry_d;
         n_q            <= n_d;
         op_q           <= op_d;
         emit_operand_q <= emit_operand_d;
         emit_opcode_q  <= emit_opcode_d;
         emit_valid_q   <= emit_valid_d;
         emit_eq_q      <= emit_eq_d;
         overflow_q     <= overflow_d;
         clear_q        <= clear_d;
         full_q         <= full_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      entry_d        = entry_q;
      n_d            = n_q;
      op_d           = op_q;
      emit_operand_d = emit_operand_q;
      emit_opcode_d  = emit_opcode_q;
      emit_valid_d   = 1'b0;
      emit_eq_d      = 1'b0;
      overflow_d     = 1'b0;
      clear_d        = 1'b0;

      if (newkey) begin
         if (keycode[4]) begin
            if (state_q == FULL) begin
               overflow_d = 1'b1;
            end else if (!lead_zero) begin
               // Shift left one nibble; the newest digit becomes least significant.
               entry_d = W'({entry_q, keycode[3:0]});
               n_d     = n_q + CW'(1);
               state_d = (n_q + CW'(1) == CW'(DIGITS)) ? FULL : ENTRY;
            end
         end else begin
            case (keycode)
               K_ADD, K_SUB, K_MUL: begin
                  if (state_q != EMPTY) begin
                     emit_valid_d   = 1'b1;
                     emit_operand_d = entry_q;
                     emit_opcode_d  = op_q;
                  end
                  op_d    = (keycode == K_ADD) ? OP_ADD :
                            (keycode == K_SUB) ? OP_SUB : OP_MUL;
                  entry_d = '0;
                  n_d     = '0;
                  state_d = EMPTY;
               end
               K_EQ: begin
                  emit_valid_d   = 1'b1;
                  emit_eq_d      = 1'b1;
                  emit_operand_d = entry_q;
                  emit_opcode_d  = op_q;
                  op_d           = OP_ADD;
                  entry_d        = '0;
                  n_d            = '0;
                  state_d        = EMPTY;
               end
               K_BS: begin
                  if (state_q != EMPTY) begin
                     entry_d = entry_q >> 4;
                     n_d     = n_q - CW'(1);
                     state_d = (n_q == CW'(1)) ? EMPTY : ENTRY;
                  end
               end
               K_CLR: begin
                  clear_d = 1'b1;
                  op_d    = OP_ADD;
                  entry_d = '0;
                  n_d     = '0;
                  state_d = EMPTY;
               end
               default: ;
            endcase
         end
      end

      full_d = (state_d == FULL);
   end

   assign entry        = entry_q;
   assign ndigits      = n_q;
   assign full         = full_q;
   assign emit_valid   = emit_valid_q;
   assign emit_operand = emit_operand_q;
   assign emit_opcode  = emit_opcode_q;
   assign emit_eq      = emit_eq_q;
   assign overflow     = overflow_q;
   assign clear        = clear_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: pulse events go through a scoreboard queue, live entry state is checked directly.
module tb_keypad_operand_entry;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        newkey = 1'b0;
   logic [4:0]  keycode = 5'b0;
   logic [15:0] entry;
   logic [2:0]  ndigits;
   logic        full;
   logic        emit_valid;
   logic [15:0] emit_operand;
   logic [1:0]  emit_opcode;
   logic        emit_eq;
   logic        overflow;
   logic        clear;

   int nvec = 0;
   int nerr = 0;

   localparam logic [4:0] K_ADD = 5'b01010;
   localparam logic [4:0] K_SUB = 5'b00011;
   localparam logic [4:0] K_MUL = 5'b00010;
   localparam logic [4:0] K_BS  = 5'b00001;
   localparam logic [4:0] K_CLR = 5'b01001;
   localparam logic [4:0] K_EQ  = 5'b00100;

`ifdef KEYPAD_LEADZERO_SUPPRESS_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   typedef struct packed {
      logic        ev;
      logic        eq;
      logic        ov;
      logic        cl;
      logic [15:0] opnd;
      logic [1:0]  opc;
   } ev_t;

   ev_t sb[$];

   keypad_operand_entry #(.DIGITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .newkey(newkey), .keycode(keycode),
      .entry(entry), .ndigits(ndigits), .full(full),
      .emit_valid(emit_valid), .emit_operand(emit_operand), .emit_opcode(emit_opcode),
      .emit_eq(emit_eq), .overflow(overflow), .clear(clear)
   );

   always #5 clk = ~clk;

   // Monitor: every presented pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && (emit_valid || overflow || clear)) begin
         ev_t act;
         ev_t exp;
         act.ev   = emit_valid;
         act.eq   = emit_eq;
         act.ov   = overflow;
         act.cl   = clear;
         act.opnd = emit_valid ? emit_operand : 16'h0;
         act.opc  = emit_valid ? emit_opcode : 2'b00;
         nvec++;
         if (sb.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_event: got %h, required none", act);
         end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
               nerr++;
               $display("FAIL event: got ev=%b eq=%b ov=%b cl=%b opnd=%h opc=%b, required ev=%b eq=%b ov=%b cl=%b opnd=%h opc=%b",
                        act.ev, act.eq, act.ov, act.cl, act.opnd, act.opc,
                        exp.ev, exp.eq, exp.ov, exp.cl, exp.opnd, exp.opc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic chk_state(input logic [15:0] e, input logic [2:0] n, input logic f);
      check("entry", 32'(entry), 32'(e));
      check("ndigits", 32'(ndigits), 32'(n));
      check("full", 32'(full), 32'(f));
   endtask

   task automatic press(input logic [4:0] code);
      @(negedge clk);
      newkey  = 1'b1;
      keycode = code;
      @(posedge clk);
      #1;
      newkey  = 1'b0;
      keycode = 5'b0;
   endtask

   task automatic digit(input logic [3:0] d);
      press({1'b1, d});
   endtask

   task automatic exp_emit(input logic [15:0] o, input logic [1:0] c, input logic eq);
      ev_t e;
      e = '{ev: 1'b1, eq: eq, ov: 1'b0, cl: 1'b0, opnd: o, opc: c};
      sb.push_back(e);
   endtask

   task automatic exp_flag(input logic ov, input logic cl);
      ev_t e;
      e = '{ev: 1'b0, eq: 1'b0, ov: ov, cl: cl, opnd: 16'h0, opc: 2'b00};
      sb.push_back(e);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_state(16'h0, 3'd0, 1'b0);
      check("rst_emit_operand", 32'(emit_operand), 32'h0);
      check("rst_emit_opcode", 32'(emit_opcode), 32'h0);
      check("rst_pulses", 32'({emit_valid, emit_eq, overflow, clear}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill to four digits
      digit(4'h1); digit(4'h2); digit(4'h3);
      chk_state(16'h0123, 3'd3, 1'b0);
      digit(4'h4);
      chk_state(16'h1234, 3'd4, 1'b1);

      // Overflow and backspace
      exp_flag(1'b1, 1'b0);
      digit(4'h5);
      chk_state(16'h1234, 3'd4, 1'b1);
      press(K_BS); press(K_BS);
      chk_state(16'h0012, 3'd2, 1'b0);
      exp_flag(1'b0, 1'b1);
      press(K_CLR);
      chk_state(16'h0, 3'd0, 1'b0);

      // Add chain with equals
      digit(4'h1); digit(4'h2);
      exp_emit(16'h0012, 2'b00, 1'b0);
      press(K_ADD);
      digit(4'h3);
      exp_emit(16'h0003, 2'b00, 1'b1);
      press(K_EQ);
      chk_state(16'h0, 3'd0, 1'b0);

      // Operator replaced while empty
      digit(4'h7);
      exp_emit(16'h0007, 2'b00, 1'b0);
      press(K_MUL);
      press(K_SUB);
      digit(4'h5);
      exp_emit(16'h0005, 2'b10, 1'b1);
      press(K_EQ);
      digit(4'h9); digit(4'h9);
      chk_state(16'h0099, 3'd2, 1'b0);
      check("hold_operand", 32'(emit_operand), 32'h0005);
      check("hold_opcode", 32'(emit_opcode), 32'h2);

      // Clear-all and ignored codes
      exp_flag(1'b0, 1'b1);
      press(K_CLR);
      chk_state(16'h0, 3'd0, 1'b0);
      digit(4'h3);
      press(5'b01000);
      press(5'b00000);
      chk_state(16'h0003, 3'd1, 1'b0);
      press(K_BS);
      press(K_BS);
      chk_state(16'h0, 3'd0, 1'b0);

      // Multiply opcode
      digit(4'h6);
      exp_emit(16'h0006, 2'b00, 1'b0);
      press(K_MUL);
      digit(4'h2);
      exp_emit(16'h0002, 2'b01, 1'b1);
      press(K_EQ);

      // Leading zero, equals on empty entry
      digit(4'h0);
      chk_state(16'h0, LZ ? 3'd0 : 3'd1, 1'b0);
      digit(4'hA);
      chk_state(16'h000A, LZ ? 3'd1 : 3'd2, 1'b0);
      exp_emit(16'h000A, 2'b00, 1'b1);
      press(K_EQ);
      exp_emit(16'h0000, 2'b00, 1'b1);
      press(K_EQ);

      // Reset mid-entry
      digit(4'hB);
      exp_emit(16'h000B, 2'b00, 1'b0);
      press(K_SUB);
      digit(4'hC);
      #2;
      rst_n = 1'b0;
      #1;
      chk_state(16'h0, 3'd0, 1'b0);
      check("mid_rst_emit_operand", 32'(emit_operand), 32'h0);
      check("mid_rst_emit_opcode", 32'(emit_opcode), 32'h0);
      check("mid_rst_pulses", 32'({emit_valid, emit_eq, overflow, clear}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      digit(4'h1);
      exp_emit(16'h0001, 2'b00, 1'b1);
      press(K_EQ);

      repeat (4) @(posedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, required finish");
      $fatal(1);
   end

endmodule
